// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, control-flow
// redirect/trap inputs and the decode-side instruction handshake.
interface fetch_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ready;
  logic [31:0]         imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                trap;
  logic                ir_valid;
  logic [31:0]         ir;
  logic [PC_WIDTH-1:0] ir_pc;
  logic                ir_ready;
  logic                misaligned;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc, misaligned,
    input  imem_ready, imem_rdata, redirect_valid, redirect_pc, trap, ir_ready
  );

  // Memory / decode / control side
  modport slave (
    input  imem_req, imem_addr, ir_valid, ir, ir_pc, misaligned,
    output imem_ready, imem_rdata, redirect_valid, redirect_pc, trap, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch per cycle
// while queue credit allows, buffers responses with their PC in a small
// circular queue and presents the head to decode. Redirect/trap flush the
// queue and squash any response still in flight.
module fetch_unit #(
  parameter int                     PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    INIT_PC  = 'h2000,
  parameter logic [PC_WIDTH-1:0]    TRAP_PC  = 'h0FFC,
  parameter int                     DEPTH    = 2,
  parameter logic [31:0]            NOP_IR   = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [PC_WIDTH-1:0] pc_reg;
  logic                active_reg;    // low until the first edge after reset
  logic                pend_reg;      // a response arrives this cycle
  logic [PC_WIDTH-1:0] pend_pc_reg;   // address of that response
  logic                mis_reg;
  logic [PTR_W-1:0]    head_reg;
  logic [PTR_W-1:0]    tail_reg;
  logic [CNT_W-1:0]    count_reg;

  // Queue storage (not reset; contents are only observed when count_reg > 0)
  logic [31:0]         ir_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem [DEPTH];

  // Per-cycle decisions
  logic                ctrl;
  logic                bad_target;
  logic                queue_valid;
  logic                pop;
  logic                write;
  logic [CNT_W:0]      occupancy;
  logic                credit;
  logic                req;
  logic                accept;

  // A misaligned redirect is demoted to a trap; a real trap wins and
  // suppresses the misaligned indication.
  assign ctrl        = bus.redirect_valid | bus.trap;
  assign bad_target  = bus.redirect_valid & ~bus.trap & (bus.redirect_pc[1:0] != 2'b00);
  assign queue_valid = (count_reg != '0);
  assign pop         = queue_valid & bus.ir_ready;
  // Flush discards a response landing in the same cycle (squash).
  assign write       = pend_reg & ~ctrl;

  // Credit counts the slot freed by a same-cycle pop so that a 2-deep
  // queue sustains one fetch per cycle. A response always finds room:
  // the occupancy that granted its request already reserved a slot.
  assign occupancy = {1'b0, count_reg}
                   + {{CNT_W{1'b0}}, pend_reg}
                   - {{CNT_W{1'b0}}, pop};
  assign credit    = (occupancy < DEPTH_L);
  assign req       = active_reg & ~ctrl & credit;
  assign accept    = req & bus.imem_ready;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_reg;
  assign bus.ir_valid   = queue_valid;
  assign bus.ir         = queue_valid ? ir_mem[head_reg] : NOP_IR;
  assign bus.ir_pc      = queue_valid ? pc_mem[head_reg] : INIT_PC;
  assign bus.misaligned = mis_reg;

  // PC sequencing, outstanding-response tracking and misaligned pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= INIT_PC;
      active_reg  <= 1'b0;
      pend_reg    <= 1'b0;
      pend_pc_reg <= INIT_PC;
      mis_reg     <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      mis_reg    <= bad_target;
      pend_reg   <= accept;
      if (accept) begin
        pend_pc_reg <= pc_reg;
      end
      if (bus.trap || bad_target) begin
        pc_reg <= TRAP_PC;
      end else if (bus.redirect_valid) begin
        pc_reg <= bus.redirect_pc;
      end else if (accept) begin
        pc_reg <= pc_reg + PC_WIDTH'(4);
      end
    end
  end

  // Queue pointers and occupancy; flush beats a same-cycle pop and write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (ctrl) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (write) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(write) - CNT_W'(pop);
    end
  end

  // Queue storage write: returned word together with its fetch address
  always_ff @(posedge clk) begin
    if (write) begin
      ir_mem[tail_reg] <= bus.imem_rdata;
      pc_mem[tail_reg] <= pend_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written back-pressure,
// wrap and async-reset sequences, and randomized traffic checked against a
// queue-based behavioural model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] INIT  = 32'h2000;
  localparam logic [31:0] TRAPV = 32'h0FFC;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.PC_WIDTH(32)) b ();
  fetch_if #(.PC_WIDTH(16)) b16 ();

  fetch_unit #(.PC_WIDTH(32), .INIT_PC(32'h2000), .TRAP_PC(32'h0FFC),
               .DEPTH(DEPTH), .NOP_IR(32'h0000_0013))
    dut (.clk(clk), .rst_n(rst_n), .bus(b.master));

  fetch_unit #(.PC_WIDTH(16), .INIT_PC(16'h2000), .TRAP_PC(16'h0FFC),
               .DEPTH(2), .NOP_IR(32'h0000_0013))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.master));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory content: a distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
  endfunction

  // Behavioural model: list of buffered {pc, word}, one pending response
  typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
  entry_t      m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_pc;
  bit          m_mis;

  task automatic model_reset();
    m_q.delete();
    m_pend = 0;
    m_pend_addr = INIT;
    m_pc = INIT;
    m_mis = 0;
  endtask

  // One clock cycle on the 32-bit unit: drive, check against model, advance model.
  // Returns at negedge+1 so the caller can inspect this cycle's outputs.
  task automatic cycle(input bit rdy, input bit ird, input bit rv,
                       input logic [31:0] rpc, input bit tr);
    bit ctrl, pop, valid, e_req, acc;
    int sz;
    entry_t e;
    @(negedge clk);
    b.imem_ready = rdy;
    b.ir_ready = ird;
    b.redirect_valid = rv;
    b.redirect_pc = rpc;
    b.trap = tr;
    b.imem_rdata = m_pend ? mem_word(m_pend_addr) : $urandom;
    #1;
    ctrl  = rv | tr;
    sz    = m_q.size();
    valid = (sz > 0);
    pop   = valid && ird;
    e_req = !ctrl && ((sz + int'(m_pend) - int'(pop)) < DEPTH);
    chk("ir_valid", b.ir_valid, valid);
    chk("ir", b.ir, valid ? m_q[0].word : NOP);
    chk("ir_pc", b.ir_pc, valid ? m_q[0].pc : INIT);
    chk("imem_req", b.imem_req, e_req);
    chk("imem_addr", b.imem_addr, m_pc);
    chk("misaligned", b.misaligned, m_mis);
    if (ctrl) begin
      m_q.delete();
      m_pend = 0;
      m_mis = !tr && (rpc[1:0] != 2'b00);
      m_pc = (tr || rpc[1:0] != 2'b00) ? TRAPV : rpc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        chk("no_overflow", m_q.size() < DEPTH, 1'b1);
        e.pc = m_pend_addr;
        e.word = mem_word(m_pend_addr);
        m_q.push_back(e);
      end
      acc = e_req && rdy;
      m_pend = acc;
      m_pend_addr = m_pc;
      if (acc) m_pc = m_pc + 32'd4;
      m_mis = 0;
    end
  endtask

  task automatic idle_inputs();
    b.imem_ready = 1; b.ir_ready = 1; b.redirect_valid = 0; b.redirect_pc = '0;
    b.trap = 0; b.imem_rdata = '0;
    b16.imem_ready = 1; b16.ir_ready = 1; b16.redirect_valid = 0; b16.redirect_pc = '0;
    b16.trap = 0; b16.imem_rdata = '0;
  endtask

  // Assert reset between clock edges, check outputs immediately, release at a negedge
  task automatic do_reset();
    #2;
    idle_inputs();
    rst_n = 0;
    #1;
    chk("rst_ir_valid", b.ir_valid, 1'b0);
    chk("rst_imem_req", b.imem_req, 1'b0);
    chk("rst_imem_addr", b.imem_addr, INIT);
    chk("rst_ir", b.ir, NOP);
    chk("rst_ir_pc", b.ir_pc, INIT);
    chk("rst_misaligned", b.misaligned, 1'b0);
    chk("rst16_imem_req", b16.imem_req, 1'b0);
    chk("rst16_imem_addr", b16.imem_addr, 16'h2000);
    chk("rst16_ir_valid", b16.ir_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    bit rdy; bit ird; bit rv; logic [31:0] rpc; bit tr;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_irpc; bit e_mis;
  } vec_t;

  vec_t tbl[13];

  initial begin
    idle_inputs();
    model_reset();

    // Directed table: sequential fetch, redirect with squash, misaligned, trap+redirect
    //          rdy ird rv rpc           tr  req addr          valid irpc          mis
    tbl[0]  = '{1, 1, 0, 32'h0,       0,  1, 32'h2000, 0, 32'h2000, 0};
    tbl[1]  = '{1, 1, 0, 32'h0,       0,  1, 32'h2004, 0, 32'h2000, 0};
    tbl[2]  = '{1, 1, 0, 32'h0,       0,  1, 32'h2008, 1, 32'h2000, 0};
    tbl[3]  = '{1, 1, 0, 32'h0,       0,  1, 32'h200C, 1, 32'h2004, 0};
    tbl[4]  = '{1, 1, 1, 32'h4000,    0,  0, 32'h2010, 1, 32'h2008, 0};
    tbl[5]  = '{1, 1, 0, 32'h0,       0,  1, 32'h4000, 0, 32'h2000, 0};
    tbl[6]  = '{1, 1, 0, 32'h0,       0,  1, 32'h4004, 0, 32'h2000, 0};
    tbl[7]  = '{1, 1, 0, 32'h0,       0,  1, 32'h4008, 1, 32'h4000, 0};
    tbl[8]  = '{1, 1, 1, 32'h4002,    0,  0, 32'h400C, 1, 32'h4004, 0};
    tbl[9]  = '{1, 1, 0, 32'h0,       0,  1, 32'h0FFC, 0, 32'h2000, 1};
    tbl[10] = '{1, 1, 0, 32'h0,       0,  1, 32'h1000, 0, 32'h2000, 0};
    tbl[11] = '{1, 1, 1, 32'h5000,    1,  0, 32'h1004, 1, 32'h0FFC, 0};
    tbl[12] = '{1, 1, 0, 32'h0,       0,  1, 32'h0FFC, 0, 32'h2000, 0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rdy, tbl[i].ird, tbl[i].rv, tbl[i].rpc, tbl[i].tr);
      chk("tbl_req", b.imem_req, tbl[i].e_req);
      chk("tbl_addr", b.imem_addr, tbl[i].e_addr);
      chk("tbl_valid", b.ir_valid, tbl[i].e_valid);
      chk("tbl_mis", b.misaligned, tbl[i].e_mis);
      if (tbl[i].e_valid) begin
        chk("tbl_ir_pc", b.ir_pc, tbl[i].e_irpc);
        chk("tbl_ir", b.ir, mem_word(tbl[i].e_irpc));
      end else begin
        chk("tbl_ir_nop", b.ir, NOP);
      end
    end

    // Back-pressure: decode stalled, credit caps accepted fetches at DEPTH
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, 0, 0, 32'h0, 0);
      if (i >= 2) begin
        chk("bp_req_low", b.imem_req, 1'b0);
        chk("bp_ir_pc_hold", b.ir_pc, 32'h2000);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 32'h0, 0);
      if (i < 3) chk("bp_release_order", b.ir_pc, 32'h2000 + 32'(4 * i));
    end

    // 16-bit PC: redirect to the top word, next fetch address wraps to zero
    do_reset();
    @(negedge clk);
    b16.redirect_valid = 1; b16.redirect_pc = 16'hFFFC;
    #1 chk("w16_req_during_redirect", b16.imem_req, 1'b0);
    @(negedge clk);
    b16.redirect_valid = 0;
    #1 chk("w16_addr_top", b16.imem_addr, 16'hFFFC);
    chk("w16_req_top", b16.imem_req, 1'b1);
    @(negedge clk);
    #1 chk("w16_addr_wrap", b16.imem_addr, 16'h0000);
    @(negedge clk);
    #1 chk("w16_ir_pc_top", b16.ir_pc, 16'hFFFC);
    @(negedge clk);
    #1 chk("w16_ir_pc_wrap", b16.ir_pc, 16'h0000);

    // Randomized traffic against the model, with mid-burst async resets
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit rdy, ird, rv, tr;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      ird = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 29) == 0);
      tr  = ($urandom_range(0, 79) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cycle(rdy, ird, rv, rpc, tr);
      if (n % 500 == 499) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
